// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit bus master.
//   size_e      : request access size encoding
//   lsu_state_e : bus-master FSM states
//   BASE_*      : peripheral base addresses decoded on the bus
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RSP  = 2'b11
    } lsu_state_e;

    localparam logic [XLEN-1:0] BASE_TIMER0 = 32'h4000_0000;
    localparam logic [XLEN-1:0] BASE_GPIO   = 32'h4000_0010;
    localparam logic [XLEN-1:0] BASE_UART   = 32'h4000_0020;

    // Illegal size, or an access that does not sit on its natural boundary.
    function automatic logic req_error(size_e size, logic [1:0] offset);
        logic err;
        case (size)
            BYTE:    err = 1'b0;
            HALF:    err = offset[0];
            WORD:    err = (offset != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Request/response handshake plus word-wide peripheral bus of the LSU.
//   master : the LSU side (accepts requests, drives the bus)
//   slave  : the pipeline/responder side
interface lsu_bus_master_if;
    import lsu_pkg::*;

    logic            i_req_valid;
    logic            o_req_ready;
    logic            i_req_we;
    logic [XLEN-1:0] i_req_addr;
    logic [XLEN-1:0] i_req_wdata;
    logic [1:0]      i_req_size;
    logic            i_req_unsigned;
    logic            o_rsp_valid;
    logic            i_rsp_ready;
    logic [XLEN-1:0] o_rsp_rdata;
    logic            o_rsp_err;
    logic            o_bus_we;
    logic [XLEN-1:0] o_bus_addr;
    logic [XLEN-1:0] o_bus_wdata;
    logic [XLEN-1:0] i_bus_rdata;

    modport master (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size,
        input  i_req_unsigned, i_rsp_ready, i_bus_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_bus_we, o_bus_addr, o_bus_wdata
    );

    modport slave (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size,
        output i_req_unsigned, i_rsp_ready, i_bus_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_bus_we, o_bus_addr, o_bus_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling for sub-word accesses.
//   i_word     : word read from the bus
//   i_wdata    : right-justified store data
//   i_size     : access size
//   i_offset   : byte offset within the word
//   i_unsigned : zero-extend loads when set
//   o_merged   : i_word with the addressed lane replaced by store data
//   o_loaded   : addressed lane, sign/zero extended to 32 bits
module lsu_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [XLEN-1:0] i_wdata,
    input  size_e           i_size,
    input  logic [1:0]      i_offset,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_merged,
    output logic [XLEN-1:0] o_loaded
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_sh  = {i_offset, 3'b000};
        half_sh  = {i_offset[1], 4'b0000};
        byte_v   = 8'(i_word >> byte_sh);
        half_v   = 16'(i_word >> half_sh);
        o_merged = i_wdata;
        o_loaded = i_word;
        case (i_size)
            BYTE: begin
                o_merged = (i_word & ~(32'h0000_00FF << byte_sh))
                         | (32'(i_wdata[7:0]) << byte_sh);
                o_loaded = i_unsigned ? 32'(byte_v) : {{24{byte_v[7]}}, byte_v};
            end
            HALF: begin
                o_merged = (i_word & ~(32'h0000_FFFF << half_sh))
                         | (32'(i_wdata[15:0]) << half_sh);
                o_loaded = i_unsigned ? 32'(half_v) : {{16{half_v[15]}}, half_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Bus initiator for MEM-stage loads/stores: one request at a time, sub-word
// stores done as read-modify-write, misaligned/illegal requests answered
// with an error and no bus activity. All outputs registered.
//   i_clk, i_rstn : clock, async active-low reset
//   bus           : request/response handshake and peripheral bus (master)
module lsu_bus_master
    import lsu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    lsu_bus_master_if.master  bus
);

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    size_e           size_q, size_d;
    logic            uns_q, uns_d;

    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            bus_we_q, bus_we_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;

    size_e           req_size_c;
    logic [XLEN-1:0] merged_c;
    logic [XLEN-1:0] loaded_c;

    assign req_size_c = size_e'(bus.i_req_size);

    // Lane logic works on the latched request and the live bus read data.
    lsu_align u_align (
        .i_word     (bus.i_bus_rdata),
        .i_wdata    (wdata_q),
        .i_size     (size_q),
        .i_offset   (addr_q[1:0]),
        .i_unsigned (uns_q),
        .o_merged   (merged_c),
        .o_loaded   (loaded_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    we_d    = bus.i_req_we;
                    addr_d  = bus.i_req_addr;
                    wdata_d = bus.i_req_wdata;
                    size_d  = req_size_c;
                    uns_d   = bus.i_req_unsigned;
                    if (req_error(req_size_c, bus.i_req_addr[1:0])) begin
                        state_d     = RSP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (bus.i_req_we && (req_size_c == WORD)) begin
                        state_d     = WR;
                        bus_addr_d  = {bus.i_req_addr[XLEN-1:2], 2'b00};
                        bus_wdata_d = bus.i_req_wdata;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        state_d    = RD;
                        bus_addr_d = {bus.i_req_addr[XLEN-1:2], 2'b00};
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_d     = WR;
                    bus_addr_d  = {addr_q[XLEN-1:2], 2'b00};
                    bus_wdata_d = merged_c;
                end else begin
                    state_d     = RSP;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = loaded_c;
                end
            end
            WR: begin
                state_d     = RSP;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            RSP: begin
                if (bus.i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake and strobe outputs follow the upcoming state.
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RSP);
        bus_we_d    = (state_d == WR);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= BYTE;
            uns_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign bus.o_req_ready = req_ready_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_bus_we    = bus_we_q;
    assign bus.o_bus_addr  = bus_addr_q;
    assign bus.o_bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed scenarios followed by
// random requests, checked against a word-memory reference model.
module tb_lsu_bus_master;
    import lsu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_bus_master_if bif ();

    lsu_bus_master dut (
        .i_clk  (clk),
        .i_rstn (rst_n),
        .bus    (bif)
    );

    // Responder: 16-word memory, combinational read, write on strobe.
    logic [31:0] mem [16] = '{default: 32'h0};
    int unsigned wr_cnt     = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    assign bif.i_bus_rdata = mem[bif.o_bus_addr[5:2]];

    always @(posedge clk) begin
        if (bif.o_bus_we) begin
            mem[bif.o_bus_addr[5:2]] <= bif.o_bus_wdata;
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= bif.o_bus_addr;
            last_wdata <= bif.o_bus_wdata;
        end
    end

    // Reference view of memory contents.
    logic [31:0] ref_mem [16] = '{default: 32'h0};

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1 && addr[0]) return 1'b1;
        if (size == 2'd2 && addr[1:0] != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [1:0] size, input logic uns);
        logic [31:0] v;
        int sh;
        if (size == 2'd0) begin
            sh = 8 * int'(addr[1:0]);
            v  = (word >> sh) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            sh = 16 * int'(addr[1]);
            v  = (word >> sh) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] addr,
                                                input logic [31:0] wdata, input logic [1:0] size);
        logic [31:0] mask;
        int sh;
        if (size == 2'd0) begin
            sh   = 8 * int'(addr[1:0]);
            mask = 32'hFF << sh;
        end else if (size == 2'd1) begin
            sh   = 16 * int'(addr[1]);
            mask = 32'hFFFF << sh;
        end else begin
            sh   = 0;
            mask = 32'hFFFF_FFFF;
        end
        return (old & ~mask) | ((wdata << sh) & mask);
    endfunction

    // One complete transaction; hold = cycles of response backpressure.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, input int hold,
                           output logic [31:0] rdata_o);
        logic        err;
        int          exp_lat;
        int          lat;
        logic [31:0] exp_rd;
        logic [31:0] new_word;
        int unsigned wc0;

        err      = model_err(size, addr);
        exp_rd   = 32'h0;
        new_word = ref_mem[addr[5:2]];
        if (err)             exp_lat = 1;
        else if (!we) begin
            exp_lat = 2;
            exp_rd  = model_load(ref_mem[addr[5:2]], addr, size, uns);
        end else begin
            exp_lat  = (size == 2'd2) ? 2 : 3;
            new_word = model_store(ref_mem[addr[5:2]], addr, wdata, size);
        end

        check("req_ready_idle", 32'(bif.o_req_ready), 32'h1);
        bif.i_req_we       = we;
        bif.i_req_addr     = addr;
        bif.i_req_wdata    = wdata;
        bif.i_req_size     = size;
        bif.i_req_unsigned = uns;
        bif.i_req_valid    = 1'b1;
        wc0 = wr_cnt;
        @(posedge clk);
        #1;
        bif.i_req_valid = 1'b0;
        lat = 1;
        while (!bif.o_rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_err", 32'(bif.o_rsp_err), 32'(err));
        check("rsp_rdata", bif.o_rsp_rdata, exp_rd);
        rdata_o = bif.o_rsp_rdata;

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bif.o_rsp_valid), 32'h1);
            check("hold_rdata", bif.o_rsp_rdata, exp_rd);
            check("hold_req_ready", 32'(bif.o_req_ready), 32'h0);
            check("hold_bus_we", 32'(bif.o_bus_we), 32'h0);
        end

        bif.i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bif.i_rsp_ready = 1'b0;
        check("ready_after_rsp", 32'(bif.o_req_ready), 32'h1);
        check("valid_after_rsp", 32'(bif.o_rsp_valid), 32'h0);

        if (we && !err) begin
            check("write_count", 32'(wr_cnt - wc0), 32'h1);
            check("write_addr", last_waddr, {addr[31:2], 2'b00});
            check("write_data", last_wdata, new_word);
            ref_mem[addr[5:2]] = new_word;
        end else begin
            check("no_write", 32'(wr_cnt - wc0), 32'h0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bif.o_req_ready), 32'h1);
        check({tag, "_rsp_valid"}, 32'(bif.o_rsp_valid), 32'h0);
        check({tag, "_rsp_rdata"}, bif.o_rsp_rdata, 32'h0);
        check({tag, "_rsp_err"}, 32'(bif.o_rsp_err), 32'h0);
        check({tag, "_bus_we"}, 32'(bif.o_bus_we), 32'h0);
        check({tag, "_bus_addr"}, bif.o_bus_addr, 32'h0);
        check({tag, "_bus_wdata"}, bif.o_bus_wdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int unsigned wc_rst;

        bif.i_req_valid    = 1'b0;
        bif.i_req_we       = 1'b0;
        bif.i_req_addr     = 32'h0;
        bif.i_req_wdata    = 32'h0;
        bif.i_req_size     = 2'd0;
        bif.i_req_unsigned = 1'b0;
        bif.i_rsp_ready    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Word store to timer.
        run_txn(1'b1, BASE_TIMER0, 32'h0000_0001, 2'd2, 1'b0, 0, rd);
        check("timer_word", ref_mem[BASE_TIMER0[5:2]], 32'h0000_0001);

        // Byte load signed/unsigned from a word 0x80FF_1234.
        run_txn(1'b1, BASE_GPIO, 32'h80FF_1234, 2'd2, 1'b0, 0, rd);
        run_txn(1'b0, BASE_GPIO + 32'd3, 32'h0, 2'd0, 1'b0, 0, rd);
        check("byte_signed", rd, 32'hFFFF_FF80);
        run_txn(1'b0, BASE_GPIO + 32'd3, 32'h0, 2'd0, 1'b1, 0, rd);
        check("byte_unsigned", rd, 32'h0000_0080);

        // Half store into existing word 0x1122_3344.
        run_txn(1'b1, BASE_UART, 32'h1122_3344, 2'd2, 1'b0, 0, rd);
        run_txn(1'b1, BASE_UART + 32'd2, 32'h0000_BEEF, 2'd1, 1'b0, 0, rd);
        check("half_merge", mem[BASE_UART[5:2]], 32'hBEEF_3344);

        // Error requests.
        run_txn(1'b0, BASE_GPIO + 32'd1, 32'h0, 2'd1, 1'b0, 0, rd);
        run_txn(1'b0, BASE_GPIO, 32'h0, 2'd3, 1'b0, 0, rd);
        run_txn(1'b1, BASE_GPIO + 32'd2, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, rd);

        // Backpressure on a load.
        run_txn(1'b0, BASE_UART + 32'd2, 32'h0, 2'd1, 1'b0, 5, rd);
        check("bp_half_load", rd, 32'hFFFF_BEEF);

        // Reset pulse during RD of a sub-word store.
        wc_rst = wr_cnt;
        bif.i_req_we    = 1'b1;
        bif.i_req_addr  = BASE_UART + 32'd1;
        bif.i_req_wdata = 32'h0000_00AA;
        bif.i_req_size  = 2'd0;
        bif.i_req_valid = 1'b1;
        @(posedge clk);
        #1;
        bif.i_req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_write", 32'(wr_cnt - wc_rst), 32'h0);
        check("midrst_idle", 32'(bif.o_req_ready), 32'h1);
        run_txn(1'b0, BASE_UART, 32'h0, 2'd2, 1'b0, 0, rd);
        check("midrst_mem", rd, 32'hBEEF_3344);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = (($urandom % 10) == 0) ? 2'd3 : 2'($urandom % 3);
            a  = BASE_TIMER0 + 32'($urandom_range(0, 63));
            run_txn(1'($urandom % 2), a, $urandom, sz, 1'($urandom % 2),
                    int'($urandom_range(0, 2)), rd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
